sign_extend_unit: RTL and testbench
===================================

// Module: sign_extend_unit
// PURPOSE
//  Immediate-extension stage of the 32-bit RISC datapath. It widens a 16-bit instruction
//  immediate to a 32-bit operand for the ALU, address adder and LUI path.
//  It is a registered, single-cycle-latency block with a mode select: sign, zero, upper
//  and byte-sign. It sits between instruction decode and operand select.
// PARAMETERS
//  IN_W    16   immediate width; BYTE mode uses bits [7:0]; must satisfy 8 <= IN_W <= OUT_W
//  OUT_W   32   extended operand width; UPPER mode requires OUT_W >= 2*IN_W
// PORTS
//  clk       in   1       system clock; all state updates on the rising edge
//  rst       in   1       synchronous, active-high reset
//  in_valid  in   1       INPUT/MODE are valid this cycle and are captured
//  MODE      in   2       00=SIGN, 01=ZERO, 10=UPPER, 11=BYTE
//  INPUT     in   IN_W    raw immediate field from the instruction
//  OUTPUT    out  OUT_W   extended operand (registered)
//  out_valid out  1       OUTPUT was updated on the last edge
// BEHAVIOUR
//  - One clock and one synchronous active-high reset (rst). The reset is sampled on the
//    rising edge of clk. No asynchronous logic.
//  - Reset: OUTPUT <= 0 and out_valid <= 0. Reset has priority over in_valid in the same
//    cycle. An in-flight capture is discarded when reset is asserted mid-operation.
//  - Latency is exactly 1 cycle. When in_valid=1 at edge N, OUTPUT holds the result and
//    out_valid=1 from edge N until edge N+1.
//  - When in_valid=0: out_valid <= 0 and OUTPUT holds its last value, so the operand stays
//    stable for stalled consumers.
//  - Back-to-back in_valid is accepted every cycle, with full throughput. There is no
//    back-pressure and no ready signal.
//  - SIGN:  OUTPUT = {{(OUT_W-IN_W){INPUT[IN_W-1]}}, INPUT}
//  - ZERO:  OUTPUT = {{(OUT_W-IN_W){1'b0}}, INPUT}
//  - UPPER: OUTPUT = INPUT << (OUT_W-IN_W). The low bits are zero-filled (LUI style).
//  - BYTE:  OUTPUT = {{(OUT_W-8){INPUT[7]}}, INPUT[7:0]}. INPUT[IN_W-1:8] is ignored.
//  - Pure bit replication and placement. There is no arithmetic, so no overflow or carry is
//    possible.
//  - Boundaries:
//    - INPUT MSB=1 in SIGN mode gives all upper bits 1.
//    - INPUT=0 in any mode gives 0.
//    - INPUT all-ones gives: SIGN -> all ones; ZERO -> 0x0000FFFF; UPPER -> 0xFFFF0000;
//      BYTE -> all ones.
//  - MODE is sampled only together with in_valid. Its value in idle cycles has no effect.
//  - OUTPUT and out_valid never carry X after the first reset edge. Internal reset is not
//    required for anything other than the output registers.
// TESTING
//  1. Hold rst=1 for 2 edges, then release.
//     -> OUTPUT=0, out_valid=0. Assert rst with in_valid=1 -> outputs still 0.
//  2. SIGN, INPUT=16'b0010111110111101 (0x2FBD), one in_valid pulse.
//     -> OUTPUT=0x00002FBD one edge later, out_valid high for 1 cycle.
//  3. SIGN 0x8001 -> 0xFFFF8001; ZERO 0x8001 -> 0x00008001; ZERO 0xFFFF -> 0x0000FFFF.
//  4. UPPER 0x2FBD -> 0x2FBD0000; BYTE 0x2FBD -> 0xFFFFFFBD; BYTE 0xFF7F -> 0x0000007F.
//  5. Back-to-back stream of 0x0001, 0xFFFF, 0x7FFF in SIGN mode on consecutive cycles.
//     -> 0x00000001, 0xFFFFFFFF, 0x00007FFF on successive edges.
//     Then drop in_valid -> out_valid=0 and OUTPUT holds 0x00007FFF.
//  6. Random 1000 vectors (INPUT, MODE, in_valid): compare against the reference model with
//     1-cycle delay. Inject rst at random points and check that outputs clear on the next
//     edge.

Source files
------------

// File: rtl/sign_extend_unit.sv
// Immediate-extension stage: widens an IN_W-bit instruction immediate to an
// OUT_W-bit operand using one of four placement modes (sign, zero, upper,
// byte-sign). The result is registered, giving exactly one cycle of latency.
// Full throughput, no back-pressure.
//
// Parameter constraints: 8 <= IN_W <= OUT_W. UPPER mode also needs
// OUT_W >= 2*IN_W. The defaults (16 -> 32) meet both.
module sign_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       MODE,
  input  logic [IN_W-1:0]  INPUT,
  output logic [OUT_W-1:0] OUTPUT,
  output logic             out_valid
);

  localparam int PAD_W  = OUT_W - IN_W;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    MODE_SIGN  = 2'b00,
    MODE_ZERO  = 2'b01,
    MODE_UPPER = 2'b10,
    MODE_BYTE  = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [OUT_W-1:0] result_d;
  logic [OUT_W-1:0] output_q;
  logic             valid_q;

  assign mode_sel = mode_e'(MODE);

  // Select the extended operand for the requested mode; pure wiring, no arithmetic.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    result_d = '0;
    unique case (mode_sel)
      MODE_SIGN:  result_d = {{PAD_W{INPUT[IN_W-1]}}, INPUT};
      MODE_ZERO:  result_d = {{PAD_W{1'b0}}, INPUT};
      MODE_UPPER: result_d = {INPUT, {PAD_W{1'b0}}};
      MODE_BYTE:  result_d = {{(OUT_W-BYTE_W){INPUT[BYTE_W-1]}}, INPUT[BYTE_W-1:0]};
      default:    result_d = '0;
    endcase
  end

  // Output register: reset wins; otherwise capture on in_valid and hold while idle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    if (rst) begin
      output_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        output_q <= result_d;
      end
    end
  end

  assign OUTPUT    = output_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_sign_extend_unit.sv
// Self-checking bench for sign_extend_unit: directed vectors per feature plus a
// randomized stream with reset injection against a reference model.
module tb_sign_extend_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [1:0]  MODE;
  logic [15:0] INPUT;
  logic [31:0] OUTPUT;
  logic        out_valid;

  int n_checks;
  int n_errors;

  sign_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .MODE     (MODE),
    .INPUT    (INPUT),
    .OUTPUT   (OUTPUT),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then step to 1 time unit past the rising edge.
  task automatic cycle(input logic r, input logic v, input logic [1:0] m,
                       input logic [15:0] d);
    rst      = r;
    in_valid = v;
    MODE     = m;
    INPUT    = d;
    @(posedge clk);
    #1;
  endtask

  // Reference extension, written from the operand definitions.
  function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] d);
    logic [7:0] b;
    b = d[7:0];
    case (m)
      2'b00:   return 32'($signed(d));
      2'b01:   return 32'(d);
      2'b10:   return {d, 16'h0000};
      default: return 32'($signed(b));
    endcase
  endfunction

  task automatic test_reset();
    cycle(1'b1, 1'b0, 2'b00, 16'h0000);
    cycle(1'b1, 1'b0, 2'b00, 16'h0000);
    n_checks++;
    if (OUTPUT !== 32'h0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hold: OUTPUT=%h out_valid=%b, expected 00000000/0", OUTPUT, out_valid);
    end
    cycle(1'b1, 1'b1, 2'b00, 16'h2FBD);
    n_checks++;
    if (OUTPUT !== 32'h0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_priority: OUTPUT=%h out_valid=%b, expected 00000000/0", OUTPUT, out_valid);
    end
    cycle(1'b0, 1'b0, 2'b00, 16'h0000);
    n_checks++;
    if (OUTPUT !== 32'h0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: OUTPUT=%h out_valid=%b, expected 00000000/0", OUTPUT, out_valid);
    end
  endtask

  task automatic test_sign_pulse();
    cycle(1'b0, 1'b1, 2'b00, 16'h2FBD);
    n_checks++;
    if (OUTPUT !== 32'h00002FBD || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL sign_pulse: OUTPUT=%h out_valid=%b, expected 00002FBD/1", OUTPUT, out_valid);
    end
    // Idle cycle with a different MODE/INPUT must not disturb the held operand.
    cycle(1'b0, 1'b0, 2'b10, 16'hFFFF);
    n_checks++;
    if (OUTPUT !== 32'h00002FBD || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL sign_pulse_hold: OUTPUT=%h out_valid=%b, expected 00002FBD/0", OUTPUT, out_valid);
    end
  endtask

  task automatic test_modes();
    // {mode, input, expected}
    logic [49:0] vec [14];
    vec = '{
      {2'b00, 16'h8001, 32'hFFFF8001},
      {2'b01, 16'h8001, 32'h00008001},
      {2'b01, 16'hFFFF, 32'h0000FFFF},
      {2'b10, 16'h2FBD, 32'h2FBD0000},
      {2'b11, 16'h2FBD, 32'hFFFFFFBD},
      {2'b11, 16'hFF7F, 32'h0000007F},
      {2'b00, 16'hFFFF, 32'hFFFFFFFF},
      {2'b10, 16'hFFFF, 32'hFFFF0000},
      {2'b11, 16'hFFFF, 32'hFFFFFFFF},
      {2'b00, 16'h0000, 32'h00000000},
      {2'b01, 16'h0000, 32'h00000000},
      {2'b10, 16'h0000, 32'h00000000},
      {2'b11, 16'h0000, 32'h00000000},
      {2'b11, 16'h0180, 32'hFFFFFF80}
    };
    for (int i = 0; i < 14; i++) begin
      logic [49:0] v;
      v = vec[i];
      cycle(1'b0, 1'b1, v[49:48], v[47:32]);
      n_checks++;
      if (OUTPUT !== v[31:0] || out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL mode_vec%0d: mode=%b in=%h OUTPUT=%h out_valid=%b, expected %h/1",
                 i, v[49:48], v[47:32], OUTPUT, out_valid, v[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] din  [3];
    logic [31:0] dexp [3];
    din  = '{16'h0001, 16'hFFFF, 16'h7FFF};
    dexp = '{32'h00000001, 32'hFFFFFFFF, 32'h00007FFF};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 2'b00, din[i]);
      n_checks++;
      if (OUTPUT !== dexp[i] || out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_%0d: OUTPUT=%h out_valid=%b, expected %h/1", i, OUTPUT, out_valid, dexp[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 2'(i + 1), 16'h1234);
      n_checks++;
      if (OUTPUT !== 32'h00007FFF || out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_drop%0d: OUTPUT=%h out_valid=%b, expected 00007FFF/0", i, OUTPUT, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_out;
    logic        exp_valid;
    logic        r, v;
    logic [1:0]  m;
    logic [15:0] d;
    exp_out   = OUTPUT === 32'h00007FFF ? 32'h00007FFF : 32'h0;
    // Start from a known state so the model does not depend on earlier tasks.
    cycle(1'b1, 1'b0, 2'b00, 16'h0000);
    exp_out   = 32'h0;
    exp_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      r = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 3) != 0);
      m = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      cycle(r, v, m, d);
      if (r) begin
        exp_out   = 32'h0;
        exp_valid = 1'b0;
      end else begin
        exp_valid = v;
        if (v) exp_out = ref_ext(m, d);
      end
      n_checks++;
      if (OUTPUT !== exp_out || out_valid !== exp_valid) begin
        n_errors++;
        $display("FAIL random%0d: rst=%b v=%b mode=%b in=%h OUTPUT=%h out_valid=%b, expected %h/%b",
                 i, r, v, m, d, OUTPUT, out_valid, exp_out, exp_valid);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    MODE     = 2'b00;
    INPUT    = 16'h0000;
    test_reset();
    test_sign_pulse();
    test_modes();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
